// File: rtl/nor_from_nand_serial.sv
// Bit-serial bitwise NOR built from a NAND-only bit slice. Result valid WIDTH cycles after accept.
// Takes no new operands until the result is taken. y is held in DONE while out_ready is low.
module nor_from_nand_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;

    logic w_a0;
    logic w_b0;
    logic w_n1;
    logic w_n2;
    logic w_n3;
    logic w_bit;
    logic w_last;

    // The operands stay frozen; the counter selects the current bit, LSB first.
    assign w_a0   = r_a[r_cnt];
    assign w_b0   = r_b[r_cnt];
    assign w_n1   = ~(w_a0 & w_a0);
    assign w_n2   = ~(w_b0 & w_b0);
    assign w_n3   = ~(w_n1 & w_n2);
    assign w_bit  = ~(w_n3 & w_n3);
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        y         = '0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                y         = r_res;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_cnt <= '0;
                        r_res <= '0;
                    end
                end
                S_SHIFT: begin
                    // Bit i lands at position i after exactly WIDTH shifts from the top.
                    r_res <= {w_bit, r_res[WIDTH-1:1]};
                    if (!w_last) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nor_from_nand_serial.sv
// Self-checking bench for nor_from_nand_serial at WIDTH=8 and WIDTH=4 against an arithmetic NOR model.
module tb_nor_from_nand_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] y;
    logic       busy;

    logic       in_valid4 = 1'b0;
    logic       in_ready4;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       out_valid4;
    logic       out_ready4 = 1'b0;
    logic [3:0] y4;
    logic       busy4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nor_from_nand_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
    );

    nor_from_nand_serial #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
        .out_valid(out_valid4), .out_ready(out_ready4), .y(y4), .busy(busy4)
    );

    function automatic logic [7:0] model_nor8(input logic [7:0] x, input logic [7:0] z);
        return ~(x | z);
    endfunction

    // Offer one operand pair from IDLE, scramble inputs afterwards, and count edges to out_valid.
    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_v,
                           output int lat, output logic [7:0] yv);
        @(negedge clk);
        a = ta; b = tb_v; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        yv = y;
    endtask

    task automatic release8();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, y} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_outputs8: got rdy=%b vld=%b busy=%b y=%h, want rdy=1 vld=0 busy=0 y=00",
                     in_ready, out_valid, busy, y);
        end
        n_checks++;
        if ({in_ready4, out_valid4, busy4, y4} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs4: got rdy=%b vld=%b busy=%b y=%h, want rdy=1 vld=0 busy=0 y=0",
                     in_ready4, out_valid4, busy4, y4);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] ta [3] = '{8'h00, 8'hF0, 8'hA0};
        logic [7:0] tv [3] = '{8'h00, 8'h0F, 8'h05};
        logic [7:0] ye [3] = '{8'hFF, 8'h00, 8'h5A};
        int lat;
        logic [7:0] yv;
        for (int i = 0; i < 3; i++) begin
            run_op8(ta[i], tv[i], lat, yv);
            n_checks++;
            if (lat !== 8) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, want 8", i, lat);
            end
            n_checks++;
            if (yv !== ye[i]) begin
                n_fail++;
                $display("FAIL directed_y[%0d]: got %h, want %h", i, yv, ye[i]);
            end
            release8();
        end
    endtask

    task automatic test_busy_handshake();
        @(negedge clk);
        a = 8'h12; b = 8'h34; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            n_checks++;
            if ({busy, in_ready, out_valid, y} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
                n_fail++;
                $display("FAIL shift_flags[%0d]: got busy=%b rdy=%b vld=%b y=%h, want 1 0 0 00",
                         c, busy, in_ready, out_valid, y);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if ({busy, in_ready, out_valid, y} !== {1'b0, 1'b0, 1'b1, model_nor8(8'h12, 8'h34)}) begin
            n_fail++;
            $display("FAIL done_flags: got busy=%b rdy=%b vld=%b y=%h, want 0 0 1 %h",
                     busy, in_ready, out_valid, y, model_nor8(8'h12, 8'h34));
        end
        release8();
        n_checks++;
        if ({in_ready, out_valid, y} !== {1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL idle_after_release: got rdy=%b vld=%b y=%h, want 1 0 00", in_ready, out_valid, y);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [7:0] yv;
        run_op8(8'hA0, 8'h05, lat, yv);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready, y} !== {1'b1, 1'b0, 8'h5A}) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got vld=%b rdy=%b y=%h, want 1 0 5a",
                         c, out_valid, in_ready, y);
            end
        end
        in_valid = 1'b0;
        release8();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL backpressure_exit: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_input_blocking();
        int lat;
        @(negedge clk);
        a = 8'h00; b = 8'h00; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 8'hFF; b = 8'hFF;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (lat !== 8 || y !== 8'hFF) begin
            n_fail++;
            $display("FAIL input_blocking: got lat=%0d y=%h, want lat=8 y=ff", lat, y);
        end
        release8();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        logic [7:0] yv;
        @(negedge clk);
        a = 8'h55; b = 8'h11; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, busy, y, in_ready} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid_op: got vld=%b busy=%b y=%h rdy=%b, want 0 0 00 1",
                     out_valid, busy, y, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op8(8'h0F, 8'h30, lat, yv);
        n_checks++;
        if (lat !== 8 || yv !== 8'hC0) begin
            n_fail++;
            $display("FAIL after_reset_op: got lat=%0d y=%h, want lat=8 y=c0", lat, yv);
        end
        release8();
    endtask

    task automatic test_random();
        int lat;
        logic [7:0] yv, ra, rb;
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op8(ra, rb, lat, yv);
            n_checks++;
            if (lat !== 8 || yv !== model_nor8(ra, rb)) begin
                n_fail++;
                $display("FAIL random[%0d] a=%h b=%h: got lat=%0d y=%h, want lat=8 y=%h",
                         i, ra, rb, lat, yv, model_nor8(ra, rb));
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            release8();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [7:0] yv;
        run_op8(8'h3C, 8'h81, lat, yv);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1; a = 8'hC3; b = 8'h00;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if ({in_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL no_passthrough: got rdy=%b busy=%b, want 1 0", in_ready, busy);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== 8 || y !== model_nor8(8'hC3, 8'h00)) begin
            n_fail++;
            $display("FAIL back_to_back: got lat=%0d y=%h, want lat=8 y=%h", lat, y, model_nor8(8'hC3, 8'h00));
        end
        release8();
    endtask

    task automatic test_width4();
        int lat;
        @(negedge clk);
        a4 = 4'h3; b4 = 4'h4; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0; a4 = 4'hF; b4 = 4'hF;
        lat = 0;
        while (!out_valid4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== 4 || y4 !== 4'h8) begin
            n_fail++;
            $display("FAIL width4: got lat=%0d y=%h, want lat=4 y=8", lat, y4);
        end
        @(negedge clk);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        n_checks++;
        if ({in_ready4, out_valid4, y4} !== {1'b1, 1'b0, 4'h0}) begin
            n_fail++;
            $display("FAIL width4_exit: got rdy=%b vld=%b y=%h, want 1 0 0", in_ready4, out_valid4, y4);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_handshake();
        test_backpressure();
        test_input_blocking();
        test_reset_mid_op();
        test_random();
        test_back_to_back();
        test_width4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nor_from_nand_serial.md
NOR_FROM_NAND_SERIAL -- requirements
Module: nor_from_nand_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits; legal range is WIDTH >= 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset; one clock, reset asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand pair on a/b is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-006 SHALL have port a, input, WIDTH bits: operand A.
REQ-007 SHALL have port b, input, WIDTH bits: operand B.
REQ-008 SHALL have port out_valid, output, 1 bit: y holds a completed result.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes y this cycle.
REQ-010 SHALL have port y, output, WIDTH bits: result, equal to bitwise NOR of captured a and b.
REQ-011 SHALL have port busy, output, 1 bit: high while in SHIFT.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE, busy=1 only in SHIFT, and out_valid=1 only in DONE; in_ready and out_valid are never high together.
REQ-014 SHALL, in IDLE on an edge with in_valid=1, capture a and b into shift registers, clear the bit counter, and go to SHIFT.
REQ-015 SHALL ignore a, b and in_valid in SHIFT and DONE, and hold the captured operands unchanged.
REQ-016 SHALL process one bit per cycle in SHIFT, LSB first, using a NAND-only bit datapath:
- n1 = NAND(a0,a0)
- n2 = NAND(b0,b0)
- n3 = NAND(n1,n2)
- bit = NAND(n3,n3)
REQ-017 SHALL shift each computed bit into the result register from the MSB end, so result bit i equals NOR(a[i],b[i]) after WIDTH shifts.
REQ-018 SHALL use a counter of clog2(WIDTH) bits with no wrap inside one operation, and move SHIFT->DONE on the edge where counter == WIDTH-1 (the WIDTH-th shift).
REQ-019 SHALL raise out_valid exactly WIDTH cycles after the accepting edge; accept at edge k gives out_valid=1 after edge k+WIDTH.
REQ-020 SHALL hold y stable and out_valid high in DONE until an edge with out_ready=1, then go to IDLE.
REQ-021 SHALL provide no pass-through: a new operand is accepted no earlier than the cycle after DONE exits. Minimum throughput is one operation per WIDTH+2 cycles.
REQ-022 SHALL drive y to 0 outside DONE.
REQ-023 SHALL give in_valid and out_ready no effect in states where they are not sampled.

Reset
REQ-024 SHALL, on rst=1 and independent of clk, force:
- state=IDLE
- in_ready=1 (combinational from IDLE)
- out_valid=0, busy=0, y=0
- counter, operand and result registers = 0
REQ-025 SHALL, on reset mid-operation (SHIFT or DONE), abandon the operation with no result emitted; the first operation after rst deasserts completes correctly.

Verification
REQ-026 SHALL pass a=8'h00, b=8'h00 -> out_valid after 8 cycles with y=8'hFF.
REQ-027 SHALL pass a=8'hF0, b=8'h0F -> y=8'h00; a=8'hA0, b=8'h05 -> y=8'h5A.
REQ-028 SHALL pass backpressure: out_ready=0 for 5 cycles in DONE -> y=8'h5A held, out_valid=1, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-029 SHALL pass input blocking: in_valid=1 with a=8'hFF, b=8'hFF during SHIFT of a=8'h00, b=8'h00 -> ignored; result y=8'hFF.
REQ-030 SHALL pass reset mid-operation: rst pulse at 3rd SHIFT cycle -> immediate out_valid=0, busy=0, y=0, in_ready=1; the next op a=8'h0F, b=8'h30 -> y=8'hC0.
REQ-031 SHALL pass a WIDTH=4 instance: a=4'h3, b=4'h4 -> y=4'h8 after 4 cycles.
